// File: rtl/serial_frame_rx.sv
// Serial frame receiver: one bit per clock, start bit, DATA_W data bits LSB-first,
// optional even/odd parity bit, stop bit. Registered valid/parity/framing pulses.
module serial_frame_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DATA      = 3'd1,
    S_PARITY    = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_bit_q, par_bit_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                par_err_q, par_err_d;
  logic                frm_err_q, frm_err_d;
  logic                busy_q, busy_d;
  logic                exp_par;

  // Parity the frame should carry, given the bits shifted in so far.
  assign exp_par = (^shreg_q) ^ 1'(PARITY_ODD);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!d) state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
        state_d = d ? S_IDLE : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (d) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    frm_err_d  = 1'b0;
    busy_d     = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (!d) cnt_d = '0;
      end
      S_DATA: begin
        shreg_d = {d, shreg_q[DATA_W-1:1]};
        cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
      end
      S_PARITY: begin
        par_bit_d = d;
      end
      S_STOP: begin
        if (d) begin
          data_out_d = shreg_q;
          valid_d    = 1'b1;
          par_err_d  = (PARITY_EN != 0) ? (exp_par != par_bit_q) : 1'b0;
        end else begin
          frm_err_d  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign par_err  = par_err_q;
  assign frm_err  = frm_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed bit stream, frame-level reference model
// checked every cycle, plus literal expectations on the observed pulses.
module tb_serial_frame_rx;

  localparam int unsigned DW   = 8;
  localparam int unsigned PE   = 1;
  localparam bit          PODD = 1'b0;
  localparam int          FLEN = DW + 2 + PE;
  localparam int          MAXN = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          d   = 1'b1;
  logic [DW-1:0] data_out;
  logic          valid, par_err, frm_err, busy;

  serial_frame_rx #(.DATA_W(DW), .PARITY_EN(PE), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .d(d), .data_out(data_out),
    .valid(valid), .par_err(par_err), .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus per edge, and expected outputs in the cycle after that edge
  logic          rst_a [MAXN];
  logic          d_a   [MAXN];
  logic          e_val [MAXN];
  logic          e_perr[MAXN];
  logic          e_frm [MAXN];
  logic          e_busy[MAXN];
  logic [DW-1:0] e_ld  [MAXN];
  logic [DW-1:0] e_data[MAXN];
  int            n = 0;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] obs_data[$];
  logic          obs_perr[$];
  int            obs_cyc [$];
  int            obs_frm = 0;

  task automatic push(input logic r, input logic b);
    rst_a[n] = r;
    d_a[n]   = b;
    n++;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) push(1'b0, 1'b1);
  endtask

  task automatic frame(input logic [DW-1:0] v, input logic pbit, input logic stop);
    push(1'b0, 1'b0);
    for (int b = 0; b < DW; b++) push(1'b0, v[b]);
    if (PE != 0) push(1'b0, pbit);
    push(1'b0, stop);
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Frame-level reading of the stimulus: where frames start and end, what they carry
  task automatic build_model();
    int k, s, e, r, j;
    logic [DW-1:0] v, held;
    logic pb;
    for (int i = 0; i < n; i++) begin
      e_val[i] = 1'b0; e_perr[i] = 1'b0; e_frm[i] = 1'b0; e_busy[i] = 1'b0; e_ld[i] = '0;
    end
    k = 0;
    while (k < n) begin
      if (rst_a[k] || d_a[k]) begin
        k++;
      end else begin
        s = k;
        e = s + FLEN - 1;
        r = -1;
        for (int i = s + 1; i <= e && i < n; i++) if (r < 0 && rst_a[i]) r = i;
        if (r >= 0 || e >= n) begin
          // Frame aborted by reset (or stream ends): busy until the reset edge
          for (int i = s; i < ((r >= 0) ? r : n); i++) e_busy[i] = 1'b1;
          k = (r >= 0) ? r : n;
        end else begin
          for (int i = s; i < e; i++) e_busy[i] = 1'b1;
          for (int b = 0; b < DW; b++) v[b] = d_a[s + 1 + b];
          pb = (PE != 0) ? d_a[s + 1 + DW] : 1'b0;
          if (d_a[e]) begin
            e_val[e]  = 1'b1;
            e_ld[e]   = v;
            e_perr[e] = (PE != 0) && ((((^v) ^ PODD)) != pb);
            k = e + 1;
          end else begin
            e_frm[e]  = 1'b1;
            e_busy[e] = 1'b1;
            j = e + 1;
            while (j < n && !rst_a[j] && !d_a[j]) begin
              e_busy[j] = 1'b1;
              j++;
            end
            k = (j < n && !rst_a[j]) ? j + 1 : j;
          end
        end
      end
    end
    held = '0;
    for (int i = 0; i < n; i++) begin
      if (rst_a[i]) held = '0;
      else if (e_val[i]) held = e_ld[i];
      e_data[i] = held;
    end
  endtask

  initial begin
    // Reset, then the directed frames
    push(1'b1, 1'b1); push(1'b1, 1'b1);
    idle(3);
    frame(8'hA5, 1'b0, 1'b1);
    idle(2);
    frame(8'hA5, 1'b1, 1'b1);
    idle(2);
    frame(8'hA5, 1'b0, 1'b0);
    push(1'b0, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
    idle(3);
    frame(8'h3C, 1'b0, 1'b1);
    frame(8'hFF, 1'b0, 1'b1);
    idle(2);
    push(1'b0, 1'b0);
    push(1'b0, 1'b1); push(1'b0, 1'b0); push(1'b0, 1'b1); push(1'b0, 1'b1);
    push(1'b1, 1'b0);
    idle(1);
    frame(8'h01, 1'b1, 1'b1);
    idle(3);
    push(1'b1, 1'b1);
    idle(50);
    build_model();

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = rst_a[k];
      d   = d_a[k];
      @(posedge clk);
      #1;
      chk("valid",    k, 32'(valid),    32'(e_val[k]));
      chk("par_err",  k, 32'(par_err),  32'(e_perr[k]));
      chk("frm_err",  k, 32'(frm_err),  32'(e_frm[k]));
      chk("busy",     k, 32'(busy),     32'(e_busy[k]));
      chk("data_out", k, 32'(data_out), 32'(e_data[k]));
      if (valid === 1'b1) begin
        obs_data.push_back(data_out);
        obs_perr.push_back(par_err);
        obs_cyc.push_back(k);
      end
      if (frm_err === 1'b1) obs_frm++;
    end

    // Hand-computed pulse sequence: A5 good, A5 bad parity, 3C, FF, 01
    begin
      logic [DW-1:0] lit_data[5];
      logic          lit_perr[5];
      lit_data = '{8'hA5, 8'hA5, 8'h3C, 8'hFF, 8'h01};
      lit_perr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      chk("pulse_count", 0, 32'(obs_data.size()), 32'd5);
      chk("frm_count",   0, 32'(obs_frm), 32'd1);
      for (int i = 0; i < 5; i++) begin
        if (i < obs_data.size()) begin
          chk("lit_data", i, 32'(obs_data[i]), 32'(lit_data[i]));
          chk("lit_perr", i, 32'(obs_perr[i]), 32'(lit_perr[i]));
        end
      end
      if (obs_cyc.size() >= 4) chk("b2b_gap", 0, 32'(obs_cyc[3] - obs_cyc[2]), 32'd11);
      // First frame: start sampled on edge 5, pulse after edge 15
      if (obs_cyc.size() >= 1) chk("latency", 0, 32'(obs_cyc[0]), 32'd15);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame (legal 5..16).
REQ-002 Parameter PARITY_EN, default 1; 1 = parity bit present after data, 0 = no parity bit.
REQ-003 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 d  input  1  serial line; idle high; one bit per clk cycle, no oversampling.
REQ-007 data_out  output  DATA_W  last received data word, LSB received first.
REQ-008 valid  output  1  one-cycle pulse: data_out holds a complete frame with good stop bit.
REQ-009 par_err  output  1  parity mismatch on the frame flagged by valid; meaningful only while valid=1.
REQ-010 frm_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP and WAIT_IDLE.
REQ-013 IDLE: d=0 sampled -> start bit; next state DATA, bit counter=0; d=1 -> stay in IDLE.
REQ-014 DATA: each edge shifts d into the data shift register LSB-first and increments the counter; after bit DATA_W-1 -> PARITY if PARITY_EN=1, else STOP.
REQ-015 PARITY: the sampled bit SHALL be stored; expected value = XOR of the data bits (even), inverted when PARITY_ODD=1; next state STOP.
REQ-016 STOP: d=1 -> data_out loaded, valid=1 for exactly one cycle, par_err=mismatch (0 when PARITY_EN=0), next state IDLE.
REQ-017 STOP: d=0 -> frm_err=1 for one cycle, valid=0, data_out unchanged, next state WAIT_IDLE.
REQ-018 WAIT_IDLE: stay until d=1 sampled, then IDLE; a low line SHALL never be taken as a start bit in this state.
REQ-019 Latency: start bit sampled on edge N; valid/frm_err SHALL be high in the cycle after edge N+DATA_W+1+PARITY_EN (edge N+10 for defaults).
REQ-020 Back-to-back frames: a start bit sampled on the edge right after the stop bit SHALL be accepted (zero idle gap).
REQ-021 data_out SHALL hold its value between valid pulses; par_err SHALL be 0 whenever valid=0.
REQ-022 valid and frm_err SHALL never be high in the same cycle.

Reset
REQ-023 rst=1 at any edge, including mid-frame: state=IDLE, counter=0, shift register=0, data_out=0, valid=0, par_err=0, frm_err=0, busy=0.
REQ-024 rst SHALL take priority over all FSM activity; a partial frame SHALL be discarded and produce no pulse.
REQ-025 First frame after reset release SHALL be detected normally, with no idle cycles needed beyond one d=1 sample.

Verification
REQ-026 Defaults, d = 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB-first, parity 0, stop) -> valid=1 one cycle, data_out=0xA5, par_err=0, frm_err=0.
REQ-027 Same frame with parity bit 1 -> valid=1, data_out=0xA5, par_err=1.
REQ-028 Same frame with stop bit 0, then d=0 for 3 cycles, then d=1 -> frm_err=1 one cycle, valid=0, data_out keeps the previous value, busy=1 until d=1 is sampled, then IDLE.
REQ-029 Frame 0x3C (parity 0) immediately followed by frame 0xFF (parity 0) with no gap -> two valid pulses 11 cycles apart, data_out=0x3C then 0xFF, par_err=0 both.
REQ-030 rst pulsed after 4 data bits of a frame, then frame 0x01 with parity 1 -> no pulse from the aborted frame, all outputs 0 after reset, then valid=1, data_out=0x01, par_err=0.
REQ-031 d held at 1 for 50 cycles after reset -> valid, frm_err and busy stay 0.
